// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared types and constants for the ADC capture sequencer
package adc_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } cap_state_e;

  // Control register bit positions
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;
  localparam int unsigned CTRL_CONT  = 2;
  localparam int unsigned CTRL_CLR   = 3;
  localparam int unsigned CTRL_TPAT  = 5;

  // Status register field positions
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_DONE     = 1;
  localparam int unsigned STAT_OVF      = 2;
  localparam int unsigned STAT_PFW      = 3;
  localparam int unsigned STAT_CONT     = 4;
  localparam int unsigned STAT_TPAT     = 5;
  localparam int unsigned STAT_WCNT_LSB = 12;

  localparam logic [7:0] FIFO_PAD = 8'h00;

  // DMA side expects the two 32-bit halves swapped behind an 8-bit pad
  function automatic logic [71:0] fifo_format(input logic [63:0] word);
    return {FIFO_PAD, word[31:0], word[63:32]};
  endfunction

endpackage

// File: rtl/adc_cap_packer.sv
// rtl/adc_cap_packer.sv - packs four consecutive samples into one word
module adc_cap_packer #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  accept_i,
  input  logic [DATA_W-1:0]     sample_i,
  output logic                  word_done_o,
  output logic [4*DATA_W-1:0]   word_o
);

  logic [1:0]          idx_q;
  logic [3*DATA_W-1:0] lanes_q;

  // Hold the first three samples; the fourth is taken straight from the input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= 2'd0;
      lanes_q <= '0;
    end else if (clr_i) begin
      idx_q   <= 2'd0;
      lanes_q <= '0;
    end else if (accept_i) begin
      idx_q <= idx_q + 2'd1;
      case (idx_q)
        2'd0:    lanes_q[DATA_W-1:0]          <= sample_i;
        2'd1:    lanes_q[2*DATA_W-1:DATA_W]   <= sample_i;
        2'd2:    lanes_q[3*DATA_W-1:2*DATA_W] <= sample_i;
        default: ;
      endcase
    end
  end

  assign word_done_o = accept_i && (idx_q == 2'd3);
  assign word_o      = {sample_i, lanes_q};

endmodule

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - burst capture sequencer into the DMA FIFO (option: ADC_CAP_TESTPAT_EN)
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LEN_W    = 20,
  parameter int IRQ_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [31:0]       ctrl_td,
  input  logic              ctrl_tv,
  input  logic [31:0]       len_td,
  input  logic              len_tv,
  output logic [31:0]       status_rd,
  output logic              status_rv,
  output logic              fifowr_en,
  output logic [71:0]       fifodin,
  input  logic              fifofull,
  input  logic              fifoprog_full,
  output logic              user_int_o
);

  localparam int IRQ_W = $clog2(IRQ_HOLD + 1);

  cap_state_e         state_q, state_d;
  logic [LEN_W-1:0]   len_q, wcnt_q;
  logic               cont_q, done_q, ovf_q, pfw_q;
  logic [IRQ_W-1:0]   irq_cnt_q;
  logic               fifowr_en_q, status_rv_q;
  logic [71:0]        fifodin_q;
  logic [31:0]        status_q, status_d;

  logic start_req, abort_req, clr_req;
  logic busy, arm_cyc, run_cyc, done_cyc, idle_start;
  logic accept, word_done, wr_ok, last_word, wrap;
  logic [DATA_W-1:0]   sample_mux;
  logic [4*DATA_W-1:0] word;
  logic unused_bits;

  assign start_req = ctrl_tv & ctrl_td[CTRL_START];
  assign abort_req = ctrl_tv & ctrl_td[CTRL_ABORT];
  assign clr_req   = ctrl_tv & ctrl_td[CTRL_CLR];

`ifdef ADC_CAP_TESTPAT_EN
  logic              tpat_q;
  logic [DATA_W-1:0] ramp_q;

  // Ramp restarts at zero on every arm so each burst begins at sample 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            ramp_q <= '0;
    else if (arm_cyc)      ramp_q <= '0;
    else if (sample_valid) ramp_q <= ramp_q + 1'b1;
  end

  // Test-pattern selection is latched with the start command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          tpat_q <= 1'b0;
    else if (idle_start) tpat_q <= ctrl_td[CTRL_TPAT];
  end

  assign sample_mux  = tpat_q ? ramp_q : sample_in;
  assign unused_bits = ^{ctrl_td[31:6], ctrl_td[4], len_td[31:LEN_W]};
`else
  assign sample_mux  = sample_in;
  assign unused_bits = ^{ctrl_td[31:4], len_td[31:LEN_W]};
`endif

  assign accept    = run_cyc && sample_valid && !abort_req;
  assign wr_ok     = word_done && !fifofull;
  assign last_word = wr_ok && ((wcnt_q + LEN_W'(1)) == len_q);
  assign wrap      = last_word && cont_q;

  adc_cap_packer #(.DATA_W(DATA_W)) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (arm_cyc),
    .accept_i    (accept),
    .sample_i    (sample_mux),
    .word_done_o (word_done),
    .word_o      (word)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; abort outranks start and end-of-burst
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_req && !abort_req) state_d = (len_q == '0) ? ST_DONE : ST_ARM;
      ST_ARM:  state_d = abort_req ? ST_IDLE : ST_RUN;
      ST_RUN:  begin
        if (abort_req)                state_d = ST_IDLE;
        else if (last_word && !cont_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy       = (state_q == ST_ARM) || (state_q == ST_RUN);
    arm_cyc    = (state_q == ST_ARM);
    run_cyc    = (state_q == ST_RUN);
    done_cyc   = (state_q == ST_DONE);
    idle_start = (state_q == ST_IDLE) && start_req && !abort_req;
  end

  // Burst configuration: length only while idle, mode latched at start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q  <= '0;
      cont_q <= 1'b0;
    end else begin
      if (len_tv && state_q == ST_IDLE) len_q <= len_td[LEN_W-1:0];
      if (idle_start)                   cont_q <= ctrl_td[CTRL_CONT];
    end
  end

  // Written-word counter; dropped words never count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          wcnt_q <= '0;
    else if (idle_start) wcnt_q <= '0;
    else if (wr_ok)      wcnt_q <= wrap ? '0 : wcnt_q + LEN_W'(1);
  end

  // Sticky status flags; a set in the same cycle as clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      pfw_q  <= 1'b0;
    end else begin
      if (clr_req) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
        pfw_q  <= 1'b0;
      end
      if (state_d == ST_DONE)        done_q <= 1'b1;
      if (word_done && fifofull)     ovf_q  <= 1'b1;
      if (run_cyc && fifoprog_full)  pfw_q  <= 1'b1;
    end
  end

  // FIFO write port, registered one cycle behind word completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifowr_en_q <= 1'b0;
      fifodin_q   <= '0;
    end else begin
      fifowr_en_q <= wr_ok;
      if (wr_ok) fifodin_q <= fifo_format(word);
    end
  end

  // Interrupt hold counter, reloaded on every burst end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                irq_cnt_q <= '0;
    else if (done_cyc || wrap) irq_cnt_q <= IRQ_W'(IRQ_HOLD);
    else if (irq_cnt_q != '0)  irq_cnt_q <= irq_cnt_q - IRQ_W'(1);
  end

  // Status word assembled from live state
  always_comb begin
    status_d                              = '0;
    status_d[STAT_BUSY]                   = busy;
    status_d[STAT_DONE]                   = done_q;
    status_d[STAT_OVF]                    = ovf_q;
    status_d[STAT_PFW]                    = pfw_q;
    status_d[STAT_CONT]                   = cont_q;
    status_d[STAT_WCNT_LSB +: LEN_W]      = wcnt_q;
`ifdef ADC_CAP_TESTPAT_EN
    status_d[STAT_TPAT]                   = tpat_q;
`endif
  end

  // Registered status snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q    <= '0;
      status_rv_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      status_rv_q <= 1'b1;
    end
  end

  assign status_rd  = status_q;
  assign status_rv  = status_rv_q;
  assign fifowr_en  = fifowr_en_q;
  assign fifodin    = fifodin_q;
  assign user_int_o = (irq_cnt_q != '0);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - directed self-checking bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [31:0] ctrl_td;
  logic        ctrl_tv;
  logic [31:0] len_td;
  logic        len_tv;
  logic [31:0] status_rd;
  logic        status_rv;
  logic        fifowr_en;
  logic [71:0] fifodin;
  logic        fifofull;
  logic        fifoprog_full;
  logic        user_int_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int irq_hi   = 0;
  logic [71:0] wq[$];
  int          wc[$];

  adc_capture_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .ctrl_td       (ctrl_td),
    .ctrl_tv       (ctrl_tv),
    .len_td        (len_td),
    .len_tv        (len_tv),
    .status_rd     (status_rd),
    .status_rv     (status_rv),
    .fifowr_en     (fifowr_en),
    .fifodin       (fifodin),
    .fifofull      (fifofull),
    .fifoprog_full (fifoprog_full),
    .user_int_o    (user_int_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifowr_en) begin
      wq.push_back(fifodin);
      wc.push_back(cyc);
    end
    if (user_int_o) irq_hi <= irq_hi + 1;
  end

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample_in = sample_in + 16'd1;
  endtask

  task automatic write_len(input logic [31:0] v);
    len_td = v;
    len_tv = 1'b1;
    tick();
    len_tv = 1'b0;
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    ctrl_td = v;
    ctrl_tv = 1'b1;
    tick();
    ctrl_tv = 1'b0;
  endtask

  function automatic logic [71:0] exp_word(input logic [15:0] base, input int k);
    logic [15:0] s0, s1, s2, s3;
    s0 = base + 16'(4 * k);
    s1 = s0 + 16'd1;
    s2 = s0 + 16'd2;
    s3 = s0 + 16'd3;
    return {8'h00, s1, s0, s3, s2};
  endfunction

  function automatic logic [71:0] get_word(input int i);
    if (i < wq.size()) return wq[i];
    return 'x;
  endfunction

  function automatic int get_cyc(input int i);
    if (i < wc.size()) return wc[i];
    return -1;
  endfunction

  initial begin
    int n1, wb, ib;
    logic [15:0] base;

    reset = 1'b0; sample_in = 16'h1000; sample_valid = 1'b0;
    ctrl_td = '0; ctrl_tv = 1'b0; len_td = '0; len_tv = 1'b0;
    fifofull = 1'b0; fifoprog_full = 1'b0;
    repeat (3) tick();
    check_eq("rst_wr_en", 72'(fifowr_en), 72'd0);
    check_eq("rst_fifodin", fifodin, 72'd0);
    check_eq("rst_status", 72'(status_rd), 72'd0);
    check_eq("rst_status_rv", 72'(status_rv), 72'd0);
    check_eq("rst_irq", 72'(user_int_o), 72'd0);
    reset = 1'b1;
    repeat (2) tick();
    check_eq("status_rv_after_rst", 72'(status_rv), 72'd1);

    // len=3 single burst; a length write while armed is ignored
    sample_valid = 1'b1;
    write_len(3);
    wb = wq.size(); ib = irq_hi;
    write_ctrl(32'h1);
    n1 = cyc; base = sample_in + 16'd1;
    write_len(9);
    repeat (38) tick();
    check_eq("t1_writes", 72'(wq.size() - wb), 72'd3);
    check_eq("t1_latency", 72'(get_cyc(wb) - n1), 72'd5);
    check_eq("t1_space1", 72'(get_cyc(wb + 1) - get_cyc(wb)), 72'd4);
    check_eq("t1_space2", 72'(get_cyc(wb + 2) - get_cyc(wb + 1)), 72'd4);
    for (int k = 0; k < 3; k++) check_eq($sformatf("t1_word%0d", k), get_word(wb + k), exp_word(base, k));
    check_eq("t1_wcnt", 72'(status_rd[31:12]), 72'd3);
    check_eq("t1_done", 72'(status_rd[1]), 72'd1);
    check_eq("t1_busy", 72'(status_rd[0]), 72'd0);
    check_eq("t1_irq_len", 72'(irq_hi - ib), 72'd16);

    // len=0: direct to done, no writes, interrupt still fires
    write_ctrl(32'h8);
    write_len(0);
    wb = wq.size(); ib = irq_hi;
    write_ctrl(32'h1);
    check_eq("t2_done_early", 72'(status_rd[1]), 72'd0);
    tick();
    check_eq("t2_done", 72'(status_rd[1]), 72'd1);
    check_eq("t2_wcnt", 72'(status_rd[31:12]), 72'd0);
    repeat (25) tick();
    check_eq("t2_writes", 72'(wq.size() - wb), 72'd0);
    check_eq("t2_irq_len", 72'(irq_hi - ib), 72'd16);

    // len=4 with FIFO full during the 2nd word; clear and start in one write
    write_len(4);
    wb = wq.size();
    write_ctrl(32'h9);
    n1 = cyc; base = sample_in + 16'd1;
    tick();
    check_eq("t3_clr_done", 72'(status_rd[1]), 72'd0);
    repeat (4) tick();
    fifofull = 1'b1; fifoprog_full = 1'b1;
    repeat (4) tick();
    fifofull = 1'b0; fifoprog_full = 1'b0;
    repeat (25) tick();
    check_eq("t3_writes", 72'(wq.size() - wb), 72'd4);
    check_eq("t3_word0", get_word(wb), exp_word(base, 0));
    check_eq("t3_word1", get_word(wb + 1), exp_word(base, 2));
    check_eq("t3_word3", get_word(wb + 3), exp_word(base, 4));
    check_eq("t3_ovf", 72'(status_rd[2]), 72'd1);
    check_eq("t3_pfw", 72'(status_rd[3]), 72'd1);
    check_eq("t3_done", 72'(status_rd[1]), 72'd1);
    check_eq("t3_wcnt", 72'(status_rd[31:12]), 72'd4);

    // continuous len=2 over 8 words, then abort
    repeat (20) tick();
    write_len(2);
    wb = wq.size();
    write_ctrl(32'hD);
    n1 = cyc; base = sample_in + 16'd1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 5) begin
        check_eq("t4_wr1", 72'(fifowr_en), 72'd1);
        check_eq("t4_irq_w1", 72'(user_int_o), 72'd0);
      end
      if (i == 9) check_eq("t4_irq_w2", 72'(user_int_o), 72'd1);
      if (i == 20) begin
        check_eq("t4_busy", 72'(status_rd[0]), 72'd1);
        check_eq("t4_cont", 72'(status_rd[4]), 72'd1);
      end
    end
    write_ctrl(32'h2);
    repeat (14) tick();
    check_eq("t4_irq_hold_end", 72'(user_int_o), 72'd1);
    tick();
    check_eq("t4_irq_off", 72'(user_int_o), 72'd0);
    check_eq("t4_writes", 72'(wq.size() - wb), 72'd8);
    check_eq("t4_word7", get_word(wb + 7), exp_word(base, 7));
    check_eq("t4_abort_busy", 72'(status_rd[0]), 72'd0);

    // reset mid-burst, then restart with len=1
    repeat (5) tick();
    write_len(5);
    write_ctrl(32'h1);
    repeat (5) tick();
    check_eq("t5_wr_before_rst", 72'(fifowr_en), 72'd1);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_wr_en", 72'(fifowr_en), 72'd0);
    check_eq("t5_rst_status", 72'(status_rd), 72'd0);
    check_eq("t5_rst_rv", 72'(status_rv), 72'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    write_len(1);
    wb = wq.size();
    write_ctrl(32'h1);
    base = sample_in + 16'd1;
    repeat (10) tick();
    check_eq("t5_writes", 72'(wq.size() - wb), 72'd1);
    check_eq("t5_word", get_word(wb), exp_word(base, 0));
    write_ctrl(32'h3);
    tick();
    check_eq("t5_abort_wins", 72'(status_rd[0]), 72'd0);

`ifdef ADC_CAP_TESTPAT_EN
    // internal ramp replaces the sample input
    wb = wq.size();
    write_ctrl(32'h21);
    repeat (10) tick();
    check_eq("t6_tpat_word", get_word(wb), {8'h00, 32'h0001_0000, 32'h0003_0002});
    check_eq("t6_tpat_stat", 72'(status_rd[5]), 72'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
